// File: rtl/exec_stall_sequencer.sv
// Cycle sequencer: stalls the single-cycle core for IN/OUT/DIV/MOD, absorbs HLT,
// and gates decoder write enables so no architectural state changes while stalled.
module exec_stall_sequencer #(
    parameter int unsigned DIV_CYCLES = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             RegWriteIn,
    input  logic             WriteFlagIn,
    input  logic             in_valid,
    output logic             in_ack,
    input  logic             out_ready,
    output logic             out_valid,
    output logic             div_start,
    output logic             pc_enable,
    output logic             reg_write,
    output logic             mem_write,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned DIV_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    localparam logic [5:0] OP_IN  = 6'b010101;
    localparam logic [5:0] OP_OUT = 6'b010110;
    localparam logic [5:0] OP_HLT = 6'b010111;
    localparam logic [5:0] OP_DIV = 6'b011001;
    localparam logic [5:0] OP_MOD = 6'b011010;

    typedef enum logic [2:0] {
        S_RUN      = 3'd0,
        S_WAIT_IN  = 3'd1,
        S_WAIT_OUT = 3'd2,
        S_DIV_BUSY = 3'd3,
        S_HALT     = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0]   stall_q;
    logic               halted_q;
    logic               div_last;

    assign div_last = (div_cnt_q == DIV_W'(DIV_CYCLES - 1));

    // State, divider counter, halt flag and stall counter
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_RUN;
            div_cnt_q <= '0;
            stall_q   <= '0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            halted_q  <= (state_d == S_HALT);
            if (!pc_enable && state_q != S_HALT && state_d != S_HALT && stall_q != '1)
                stall_q <= stall_q + CNT_W'(1);
        end
    end

    // Next state and Mealy enables; reset forces every enable low
    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        pc_enable = 1'b0;
        reg_write = 1'b0;
        mem_write = 1'b0;
        in_ack    = 1'b0;
        out_valid = 1'b0;
        div_start = 1'b0;

        if (!reset) begin
            case (state_q)
                S_RUN: begin
                    case (opcode)
                        OP_IN: begin
                            if (in_valid) begin
                                in_ack    = 1'b1;
                                reg_write = RegWriteIn;
                                pc_enable = 1'b1;
                            end else begin
                                state_d = S_WAIT_IN;
                            end
                        end
                        OP_OUT: begin
                            out_valid = 1'b1;
                            if (out_ready) pc_enable = 1'b1;
                            else           state_d   = S_WAIT_OUT;
                        end
                        OP_HLT: state_d = S_HALT;
                        OP_DIV, OP_MOD: begin
                            div_start = 1'b1;
                            div_cnt_d = '0;
                            state_d   = S_DIV_BUSY;
                        end
                        default: begin
                            pc_enable = 1'b1;
                            reg_write = RegWriteIn;
                            mem_write = WriteFlagIn;
                        end
                    endcase
                end
                S_WAIT_IN: begin
                    if (in_valid) begin
                        in_ack    = 1'b1;
                        reg_write = RegWriteIn;
                        pc_enable = 1'b1;
                        state_d   = S_RUN;
                    end
                end
                S_WAIT_OUT: begin
                    out_valid = 1'b1;
                    if (out_ready) begin
                        pc_enable = 1'b1;
                        state_d   = S_RUN;
                    end
                end
                S_DIV_BUSY: begin
                    if (div_last) begin
                        reg_write = RegWriteIn;
                        pc_enable = 1'b1;
                        div_cnt_d = '0;
                        state_d   = S_RUN;
                    end else begin
                        div_cnt_d = div_cnt_q + DIV_W'(1);
                    end
                end
                S_HALT:  state_d = S_HALT;
                default: state_d = S_RUN;
            endcase
        end
    end

    assign state        = state_q;
    assign halted       = halted_q;
    assign stall_cycles = stall_q;

endmodule
